// File: rtl/operand_collector_array.sv
// Eight-slot operand collector: gathers tagged bank returns, dispatches full slots.
// Define OC_RR_ARB_EN for a round-robin dispatch arbiter (default: fixed priority).
module operand_collector_array #(
    parameter int NUM_OC  = 8,
    parameter int DATA_W  = 256,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_valid,
    input  logic [2:0]         alloc_ocid,
    input  logic               alloc_src1_valid,
    input  logic               alloc_src2_valid,
    input  logic [2:0]         alloc_warp_id,
    input  logic [INSTR_W-1:0] alloc_instr,
    input  logic               rd_valid_0,
    input  logic               rd_valid_1,
    input  logic               rd_valid_2,
    input  logic               rd_valid_3,
    input  logic [3:0]         rd_ocid_0,
    input  logic [3:0]         rd_ocid_1,
    input  logic [3:0]         rd_ocid_2,
    input  logic [3:0]         rd_ocid_3,
    input  logic [DATA_W-1:0]  rd_data_0,
    input  logic [DATA_W-1:0]  rd_data_1,
    input  logic [DATA_W-1:0]  rd_data_2,
    input  logic [DATA_W-1:0]  rd_data_3,
    output logic               disp_valid,
    input  logic               disp_ready,
    output logic [2:0]         disp_ocid,
    output logic [2:0]         disp_warp_id,
    output logic [INSTR_W-1:0] disp_instr,
    output logic [DATA_W-1:0]  disp_src1,
    output logic [DATA_W-1:0]  disp_src2,
    output logic [NUM_OC-1:0]  oc_busy,
    output logic               alloc_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, READY} state_e;
    localparam int NB = 4;

    logic [NB-1:0]      rv;
    logic [3:0]         rtag [NB];
    logic [DATA_W-1:0]  rdat [NB];

    state_e             state_q [NUM_OC];
    state_e             state_d [NUM_OC];
    logic [NUM_OC-1:0]  need1_q, need1_d, need2_q, need2_d;
    logic [NUM_OC-1:0]  got1_q, got1_d, got2_q, got2_d;
    logic [2:0]         warp_q  [NUM_OC];
    logic [2:0]         warp_d  [NUM_OC];
    logic [INSTR_W-1:0] instr_q [NUM_OC];
    logic [INSTR_W-1:0] instr_d [NUM_OC];
    logic [DATA_W-1:0]  src1_q  [NUM_OC];
    logic [DATA_W-1:0]  src1_d  [NUM_OC];
    logic [DATA_W-1:0]  src2_q  [NUM_OC];
    logic [DATA_W-1:0]  src2_d  [NUM_OC];

    logic               alloc_err_q, alloc_err_d;
    logic               lock_q, lock_d;
    logic [2:0]         lock_id_q, lock_id_d;
    logic               sel_found, fire;
    logic [2:0]         sel_id, idx;
    logic               hs, al, c1, c2;

`ifdef OC_RR_ARB_EN
    logic [2:0]         ptr_q, ptr_d;
`endif

    assign rv      = {rd_valid_3, rd_valid_2, rd_valid_1, rd_valid_0};
    assign rtag[0] = rd_ocid_0;
    assign rtag[1] = rd_ocid_1;
    assign rtag[2] = rd_ocid_2;
    assign rtag[3] = rd_ocid_3;
    assign rdat[0] = rd_data_0;
    assign rdat[1] = rd_data_1;
    assign rdat[2] = rd_data_2;
    assign rdat[3] = rd_data_3;

    // A stalled offer is locked so newly ready slots cannot steal the grant.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = '0;
        if (lock_q) begin
            sel_found = 1'b1;
            sel_id    = lock_id_q;
        end else begin
            for (int k = 0; k < NUM_OC; k++) begin
`ifdef OC_RR_ARB_EN
                idx = 3'((int'(ptr_q) + k) % NUM_OC);
`else
                idx = 3'(k);
`endif
                if (!sel_found && state_q[idx] == READY) begin
                    sel_found = 1'b1;
                    sel_id    = idx;
                end
            end
        end
    end

    assign fire = sel_found & disp_ready;

    always_comb begin
        disp_valid   = sel_found;
        disp_ocid    = '0;
        disp_warp_id = '0;
        disp_instr   = '0;
        disp_src1    = '0;
        disp_src2    = '0;
        if (sel_found) begin
            disp_ocid    = sel_id;
            disp_warp_id = warp_q[sel_id];
            disp_instr   = instr_q[sel_id];
            disp_src1    = src1_q[sel_id];
            disp_src2    = src2_q[sel_id];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OC; i++) begin
            oc_busy[i] = (state_q[i] != IDLE);
        end
    end

    assign alloc_err = alloc_err_q;

    always_comb begin
        state_d = state_q;
        need1_d = need1_q;
        need2_d = need2_q;
        got1_d  = got1_q;
        got2_d  = got2_q;
        warp_d  = warp_q;
        instr_d = instr_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        hs      = 1'b0;
        al      = 1'b0;
        c1      = 1'b0;
        c2      = 1'b0;
        for (int i = 0; i < NUM_OC; i++) begin
            hs = fire && (sel_id == 3'(i));
            al = alloc_valid && (alloc_ocid == 3'(i));
            c1 = 1'b0;
            c2 = 1'b0;
            if (al && (state_q[i] == IDLE || hs)) begin
                need1_d[i] = alloc_src1_valid;
                need2_d[i] = alloc_src2_valid;
                got1_d[i]  = 1'b0;
                got2_d[i]  = 1'b0;
                warp_d[i]  = alloc_warp_id;
                instr_d[i] = alloc_instr;
                state_d[i] = (alloc_src1_valid || alloc_src2_valid) ? COLLECT : READY;
            end else if (hs) begin
                state_d[i] = IDLE;
            end else if (state_q[i] == COLLECT) begin
                // Descending scan so the lowest bank index is written last.
                for (int b = NB - 1; b >= 0; b--) begin
                    if (rv[b] && rtag[b][2:0] == 3'(i)) begin
                        if (!rtag[b][3] && need1_q[i]) begin
                            src1_d[i] = rdat[b];
                            c1        = 1'b1;
                        end
                        if (rtag[b][3] && need2_q[i]) begin
                            src2_d[i] = rdat[b];
                            c2        = 1'b1;
                        end
                    end
                end
                got1_d[i] = got1_q[i] | c1;
                got2_d[i] = got2_q[i] | c2;
                if ((got1_d[i] || !need1_q[i]) && (got2_d[i] || !need2_q[i])) begin
                    state_d[i] = READY;
                end
            end
        end
    end

    assign alloc_err_d = alloc_valid && (state_q[alloc_ocid] != IDLE)
                         && !(fire && sel_id == alloc_ocid);
    assign lock_d      = sel_found && !disp_ready;
    assign lock_id_d   = sel_id;
`ifdef OC_RR_ARB_EN
    assign ptr_d = fire ? 3'((int'(sel_id) + 1) % NUM_OC) : ptr_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_OC; i++) begin
                state_q[i] <= IDLE;
            end
            need1_q     <= '0;
            need2_q     <= '0;
            got1_q      <= '0;
            got2_q      <= '0;
            alloc_err_q <= 1'b0;
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
`ifdef OC_RR_ARB_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            need1_q     <= need1_d;
            need2_q     <= need2_d;
            got1_q      <= got1_d;
            got2_q      <= got2_d;
            alloc_err_q <= alloc_err_d;
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
`ifdef OC_RR_ARB_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    // Payload storage needs no reset; outputs are gated by disp_valid.
    always_ff @(posedge clk) begin
        warp_q  <= warp_d;
        instr_q <= instr_d;
        src1_q  <= src1_d;
        src2_q  <= src2_d;
    end

endmodule

// File: tb/tb_operand_collector_array.sv
// Bench for operand_collector_array: directed table, corner sequences, random vs model.
// Honours OC_RR_ARB_EN the same way as the design.
module tb_operand_collector_array;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_valid;
    logic [2:0]   alloc_ocid;
    logic         alloc_src1_valid, alloc_src2_valid;
    logic [2:0]   alloc_warp_id;
    logic [31:0]  alloc_instr;
    logic [3:0]   rv;
    logic [3:0]   rt  [4];
    logic [255:0] rdd [4];
    logic         disp_valid, disp_ready;
    logic [2:0]   disp_ocid, disp_warp_id;
    logic [31:0]  disp_instr;
    logic [255:0] disp_src1, disp_src2;
    logic [7:0]   oc_busy;
    logic         alloc_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_collector_array dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ocid(alloc_ocid),
        .alloc_src1_valid(alloc_src1_valid), .alloc_src2_valid(alloc_src2_valid),
        .alloc_warp_id(alloc_warp_id), .alloc_instr(alloc_instr),
        .rd_valid_0(rv[0]), .rd_valid_1(rv[1]),
        .rd_valid_2(rv[2]), .rd_valid_3(rv[3]),
        .rd_ocid_0(rt[0]), .rd_ocid_1(rt[1]),
        .rd_ocid_2(rt[2]), .rd_ocid_3(rt[3]),
        .rd_data_0(rdd[0]), .rd_data_1(rdd[1]),
        .rd_data_2(rdd[2]), .rd_data_3(rdd[3]),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ocid(disp_ocid), .disp_warp_id(disp_warp_id),
        .disp_instr(disp_instr), .disp_src1(disp_src1), .disp_src2(disp_src2),
        .oc_busy(oc_busy), .alloc_err(alloc_err)
    );

    // Reference model: each slot is an instruction waiting for its operands.
    typedef struct {
        bit           busy;
        bit           need1, need2, got1, got2;
        logic [2:0]   warp;
        logic [31:0]  instr;
        logic [255:0] s1, s2;
    } slot_t;

    slot_t m [8];
    bit    m_init = 0;
    bit    m_err, m_held;
    int    m_held_id, m_ptr;

    function automatic bit m_rdy(int s);
        return m[s].busy && (m[s].got1 || !m[s].need1) && (m[s].got2 || !m[s].need2);
    endfunction

    function automatic int m_pick();
        int base;
        int s;
        if (m_held) return m_held_id;
`ifdef OC_RR_ARB_EN
        base = m_ptr;
`else
        base = 0;
`endif
        for (int k = 0; k < 8; k++) begin
            s = (base + k) % 8;
            if (m_rdy(s)) return s;
        end
        return -1;
    endfunction

    task automatic m_update();
        slot_t n [8];
        bit    taken [8][2];
        int    pick, s, op;
        bit    fire;
        if (!rst) begin
            for (int i = 0; i < 8; i++) m[i].busy = 0;
            m_err = 0; m_held = 0; m_held_id = 0; m_ptr = 0; m_init = 1;
            return;
        end
        pick = m_pick();
        fire = (pick >= 0) && disp_ready;
        n = m;
        for (int i = 0; i < 8; i++) begin taken[i][0] = 0; taken[i][1] = 0; end
        for (int b = 0; b < 4; b++) begin
            if (rv[b]) begin
                s  = int'(rt[b][2:0]);
                op = int'(rt[b][3]);
                if (m[s].busy && !m_rdy(s) && !taken[s][op]
                    && (op == 1 ? m[s].need2 : m[s].need1)) begin
                    taken[s][op] = 1;
                    if (op == 1) begin n[s].s2 = rdd[b]; n[s].got2 = 1; end
                    else         begin n[s].s1 = rdd[b]; n[s].got1 = 1; end
                end
            end
        end
        if (fire) n[pick].busy = 0;
        m_err = 0;
        if (alloc_valid) begin
            s = int'(alloc_ocid);
            if (!m[s].busy || (fire && pick == s)) begin
                n[s].busy  = 1;
                n[s].need1 = alloc_src1_valid; n[s].need2 = alloc_src2_valid;
                n[s].got1  = 0; n[s].got2 = 0;
                n[s].warp  = alloc_warp_id; n[s].instr = alloc_instr;
            end else begin
                m_err = 1;
            end
        end
        m_held    = (pick >= 0) && !disp_ready;
        m_held_id = pick;
        if (fire) m_ptr = (pick + 1) % 8;
        m = n;
    endtask

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic m_check();
        int p;
        logic [7:0] eb;
        p = m_pick();
        chk("m_valid", disp_valid, p >= 0);
        if (p >= 0) begin
            chk("m_ocid", disp_ocid, p);
            chk("m_warp", disp_warp_id, m[p].warp);
            chk("m_instr", disp_instr, m[p].instr);
            if (m[p].need1) chk("m_src1", disp_src1, m[p].s1);
            if (m[p].need2) chk("m_src2", disp_src2, m[p].s2);
        end else begin
            chk("m_idle_out", {disp_ocid, disp_warp_id, disp_instr}, '0);
            chk("m_idle_src", disp_src1 | disp_src2, '0);
        end
        for (int i = 0; i < 8; i++) eb[i] = m[i].busy;
        chk("m_busy", oc_busy, eb);
        chk("m_err", alloc_err, m_err);
    endtask

    task automatic step();
        #1;
        if (m_init) m_check();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        alloc_valid = 0; alloc_ocid = 0;
        alloc_src1_valid = 0; alloc_src2_valid = 0;
        alloc_warp_id = 0; alloc_instr = 0;
        rv = 0;
        for (int b = 0; b < 4; b++) begin rt[b] = 0; rdd[b] = 0; end
    endtask

    task automatic do_alloc(int id, bit n1, bit n2, int w, logic [31:0] ins);
        alloc_valid = 1; alloc_ocid = 3'(id);
        alloc_src1_valid = n1; alloc_src2_valid = n2;
        alloc_warp_id = 3'(w); alloc_instr = ins;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        bit           av;
        logic [2:0]   aid;
        bit           an1, an2;
        logic [2:0]   aw;
        logic [31:0]  ai;
        int           rb;
        logic [3:0]   rtg;
        logic [255:0] rdt;
        bit           dr;
        bit           ev;
        logic [2:0]   eid, ew;
        logic [31:0]  ei;
        logic [7:0]   ebusy;
        bit           eerr;
        logic [1:0]   ecs;
        logic [255:0] e1, e2;
    } vec_t;

    localparam logic [255:0] DA = {8{32'hA5A5_0001}};
    localparam logic [255:0] DB = {8{32'hB6B6_0002}};
    localparam logic [255:0] DC = {8{32'hC7C7_0003}};
    localparam logic [255:0] DD = {8{32'hD8D8_0004}};
    localparam logic [255:0] DE = {8{32'hE9E9_0005}};
    localparam logic [255:0] DX = {8{32'h1234_5678}};

    vec_t tv [9];
    logic [2:0] order [3];

    initial begin
        // Expected outputs are those seen after the edge that consumes the row.
        tv[0] = '{1,3'd3,1,1,3'd5,32'h1111_0000, -1,4'h0,'0, 0,
                  0,3'd0,3'd0,32'd0, 8'h08,0, 2'b00,'0,'0};
        tv[1] = '{0,3'd0,0,0,3'd0,32'd0, 1,4'b0011,DA, 0,
                  0,3'd0,3'd0,32'd0, 8'h08,0, 2'b00,'0,'0};
        tv[2] = '{0,3'd0,0,0,3'd0,32'd0, 2,4'b1011,DB, 0,
                  1,3'd3,3'd5,32'h1111_0000, 8'h08,0, 2'b11,DA,DB};
        tv[3] = '{0,3'd0,0,0,3'd0,32'd0, -1,4'h0,'0, 1,
                  0,3'd0,3'd0,32'd0, 8'h00,0, 2'b00,'0,'0};
        tv[4] = '{1,3'd2,1,0,3'd1,32'h2222_0000, -1,4'h0,'0, 0,
                  0,3'd0,3'd0,32'd0, 8'h04,0, 2'b00,'0,'0};
        tv[5] = '{1,3'd2,1,1,3'd6,32'h3333_0000, -1,4'h0,'0, 0,
                  0,3'd0,3'd0,32'd0, 8'h04,1, 2'b00,'0,'0};
        tv[6] = '{0,3'd0,0,0,3'd0,32'd0, -1,4'h0,'0, 0,
                  0,3'd0,3'd0,32'd0, 8'h04,0, 2'b00,'0,'0};
        tv[7] = '{0,3'd0,0,0,3'd0,32'd0, 0,4'b0010,DC, 0,
                  1,3'd2,3'd1,32'h2222_0000, 8'h04,0, 2'b01,DC,'0};
        tv[8] = '{0,3'd0,0,0,3'd0,32'd0, -1,4'h0,'0, 1,
                  0,3'd0,3'd0,32'd0, 8'h00,0, 2'b00,'0,'0};

        idle_in();
        disp_ready = 0;
        rst = 0;
        step();
        rst = 1;
        chk("reset_busy", oc_busy, 8'h00);
        chk("reset_valid", disp_valid, 1'b0);
        chk("reset_err", alloc_err, 1'b0);
        chk("reset_out", {disp_ocid, disp_warp_id, disp_instr}, '0);
        chk("reset_src", disp_src1 | disp_src2, '0);

        for (int k = 0; k < 9; k++) begin
            idle_in();
            if (tv[k].av) do_alloc(tv[k].aid, tv[k].an1, tv[k].an2, tv[k].aw, tv[k].ai);
            if (tv[k].rb >= 0) begin
                rv[tv[k].rb] = 1; rt[tv[k].rb] = tv[k].rtg; rdd[tv[k].rb] = tv[k].rdt;
            end
            disp_ready = tv[k].dr;
            step();
            chk($sformatf("tbl%0d_valid", k), disp_valid, tv[k].ev);
            if (tv[k].ev) begin
                chk($sformatf("tbl%0d_ocid", k), disp_ocid, tv[k].eid);
                chk($sformatf("tbl%0d_warp", k), disp_warp_id, tv[k].ew);
                chk($sformatf("tbl%0d_instr", k), disp_instr, tv[k].ei);
            end
            if (tv[k].ecs[0]) chk($sformatf("tbl%0d_src1", k), disp_src1, tv[k].e1);
            if (tv[k].ecs[1]) chk($sformatf("tbl%0d_src2", k), disp_src2, tv[k].e2);
            chk($sformatf("tbl%0d_busy", k), oc_busy, tv[k].ebusy);
            chk($sformatf("tbl%0d_err", k), alloc_err, tv[k].eerr);
        end

        // Slot 5: both operands in one cycle, bank 0 beats bank 1 on src1.
        idle_in(); disp_ready = 0;
        do_alloc(5, 1, 1, 2, 32'h5555_0000);
        step();
        idle_in();
        rv = 4'b1011;
        rt[0] = 4'b0101; rdd[0] = DD;
        rt[1] = 4'b0101; rdd[1] = DX;
        rt[3] = 4'b1101; rdd[3] = DE;
        step();
        idle_in();
        chk("same_valid", disp_valid, 1'b1);
        chk("same_ocid", disp_ocid, 3'd5);
        chk("same_src1", disp_src1, DD);
        chk("same_src2", disp_src2, DE);
        disp_ready = 1;
        step();
        chk("same_busy", oc_busy, 8'h00);

        // Slot 0 stalled for three cycles while stale returns arrive.
        idle_in(); disp_ready = 0;
        do_alloc(0, 1, 1, 7, 32'h0F0F_0000);
        step();
        idle_in();
        rv = 4'b0011; rt[0] = 4'b0000; rdd[0] = DA; rt[1] = 4'b1000; rdd[1] = DB;
        step();
        for (int c = 0; c < 3; c++) begin
            idle_in();
            rv = 4'b0011; rt[0] = 4'b0000; rdd[0] = DX; rt[1] = 4'b1000; rdd[1] = DX;
            step();
            chk("stall_valid", disp_valid, 1'b1);
            chk("stall_ocid", disp_ocid, 3'd0);
            chk("stall_src1", disp_src1, DA);
            chk("stall_src2", disp_src2, DB);
        end
        idle_in(); disp_ready = 1;
        step();
        chk("stall_free", oc_busy, 8'h00);

        // Arbitration order from a fresh pointer.
        idle_in(); disp_ready = 0; rst = 0;
        step();
        rst = 1;
        do_alloc(1, 0, 0, 1, 32'hA1); step();
        do_alloc(4, 0, 0, 4, 32'hA4); step();
        do_alloc(6, 0, 0, 6, 32'hA6); step();
        idle_in(); disp_ready = 1;
        order[0] = 3'd1; order[1] = 3'd4; order[2] = 3'd6;
        for (int k = 0; k < 3; k++) begin
            chk("arb_valid", disp_valid, 1'b1);
            chk("arb_order", disp_ocid, order[k]);
            step();
        end
        chk("arb_empty", disp_valid, 1'b0);
        do_alloc(4, 0, 0, 4, 32'hB4);
        step();
        idle_in();
        chk("arb_p5_ocid", disp_ocid, 3'd4);
        step();
        disp_ready = 0;
        do_alloc(1, 1, 0, 1, 32'hC1); step();
        do_alloc(6, 1, 0, 6, 32'hC6); step();
        idle_in();
        rv = 4'b0011; rt[0] = 4'b0001; rdd[0] = DC; rt[1] = 4'b0110; rdd[1] = DD;
        step();
        idle_in(); disp_ready = 1;
`ifdef OC_RR_ARB_EN
        order[0] = 3'd6; order[1] = 3'd1;
`else
        order[0] = 3'd1; order[1] = 3'd6;
`endif
        for (int k = 0; k < 2; k++) begin
            chk("arb2_order", disp_ocid, order[k]);
            step();
        end
        chk("arb2_empty", oc_busy, 8'h00);

        // Reset in the middle of collection with every slot busy.
        idle_in(); disp_ready = 0;
        for (int i = 0; i < 8; i++) begin
            do_alloc(i, 1, 1, i, 32'(i));
            step();
        end
        idle_in();
        chk("full_busy", oc_busy, 8'hFF);
        rst = 0;
        rv = 4'b0001; rt[0] = 4'b0000; rdd[0] = DA;
        step();
        rst = 1;
        chk("mid_rst_busy", oc_busy, 8'h00);
        chk("mid_rst_valid", disp_valid, 1'b0);
        rv = 4'b0100; rt[2] = 4'b0000; rdd[2] = DB;
        step();
        chk("stale_busy", oc_busy, 8'h00);
        chk("stale_valid", disp_valid, 1'b0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            idle_in();
            rst = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 2) == 0)
                do_alloc($urandom_range(0, 7), 1'($urandom), 1'($urandom),
                         $urandom_range(0, 7), $urandom);
            for (int b = 0; b < 4; b++) begin
                rv[b]  = 1'($urandom_range(0, 1));
                rt[b]  = 4'($urandom_range(0, 15));
                rdd[b] = rnd256();
            end
            disp_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        rst = 1;
        idle_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
